// File: rtl/reg_file_alu_pkg.sv
// Shared widths and ALU operation encoding for the register-file/ALU datapath slice.
package reg_file_alu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_PASSB = 2'b01,
        ALU_AND   = 2'b10,
        ALU_SUB   = 2'b11
    } alu_op_t;

endpackage

// File: rtl/reg_file_alu_alu8.sv
// Purely combinational 8-bit ALU: add, pass B, bitwise AND, subtract.
// All arithmetic wraps modulo 2**DATA_W; no flags are produced.
module alu8
    import reg_file_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] y_s;

    // Select the operation result; carries out of the top bit are dropped.
    always_comb begin
        y_s = {DATA_W{1'b0}};
        case (op)
            ALU_ADD:   y_s = a + b;
            ALU_PASSB: y_s = b;
            ALU_AND:   y_s = a & b;
            ALU_SUB:   y_s = a - b;
            default:   y_s = {DATA_W{1'b0}};
        endcase
    end

    assign y = y_s;

endmodule

// File: rtl/reg_file_alu.sv
// Single-cycle datapath slice: 16x8 register file with two combinational read
// ports and one synchronous write port, feeding an 8-bit ALU whose result is
// both the block output and the write-back data. The register breaks the
// write-back loop, so ALUResult only ever depends on already-stored values.
module reg_file_alu
    import reg_file_alu_pkg::*;
(
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] external_data_in,
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic              ALUSrc,
    input  logic [1:0]        ALUControl,
    output logic [DATA_W-1:0] ALUResult
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] op_b_s;
    logic [DATA_W-1:0] alu_y_s;
    alu_op_t           alu_op_s;

    // Zero-latency reads; a same-cycle write is not bypassed, so old data is seen.
    assign rd1_s = regs_q[RA1];
    assign rd2_s = regs_q[RA2];

    // Operand B comes from the second read port or the external immediate byte.
    always_comb begin
        op_b_s = rd2_s;
        if (ALUSrc) begin
            op_b_s = external_data_in;
        end else begin
            op_b_s = rd2_s;
        end
    end

    assign alu_op_s = alu_op_t'(ALUControl);

    alu8 u_alu (
        .a  (rd1_s),
        .b  (op_b_s),
        .op (alu_op_s),
        .y  (alu_y_s)
    );

    assign ALUResult = alu_y_s;

    // Next register contents: only the addressed entry changes, and only when enabled.
    always_comb begin
        regs_d = regs_q;
        if (RegWrite) begin
            regs_d[WA] = alu_y_s;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register array update; reset wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: {DATA_W{1'b0}}};
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_reg_file_alu.sv
// Self-checking bench for reg_file_alu: directed scenarios followed by random
// traffic, all compared against an array-based behavioural model.
module tb_reg_file_alu;

    logic [3:0] RA1;
    logic [3:0] RA2;
    logic [3:0] WA;
    logic [7:0] external_data_in;
    logic       clk;
    logic       reset;
    logic       RegWrite;
    logic       ALUSrc;
    logic [1:0] ALUControl;
    logic [7:0] ALUResult;

    int n_checks;
    int n_errors;

    logic [7:0] model_regs [16];

    reg_file_alu dut (
        .RA1              (RA1),
        .RA2              (RA2),
        .WA               (WA),
        .external_data_in (external_data_in),
        .clk              (clk),
        .reset            (reset),
        .RegWrite         (RegWrite),
        .ALUSrc           (ALUSrc),
        .ALUControl       (ALUControl),
        .ALUResult        (ALUResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and count it.
    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Reference ALU from the operation table, using plain integer arithmetic.
    function automatic logic [7:0] ref_alu(input logic [1:0] op, input int a, input int b);
        int r;
        case (op)
            2'd0:    r = (a + b) % 256;
            2'd1:    r = b;
            2'd2:    r = a & b;
            2'd3:    r = (a - b + 256) % 256;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    // One clock cycle: drive inputs at the falling edge, check the combinational
    // result mid-cycle, then let the rising edge commit and mirror it in the model.
    task automatic cycle(input string tag,
                         input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa,
                         input logic [7:0] ext, input logic we, input logic src,
                         input logic [1:0] op, input logic rst,
                         input bit do_check, input bit have_want, input logic [7:0] want);
        logic [7:0] exp_v;
        int b_val;
        @(negedge clk);
        RA1 = ra1; RA2 = ra2; WA = wa; external_data_in = ext;
        RegWrite = we; ALUSrc = src; ALUControl = op; reset = rst;
        b_val = src ? int'(ext) : int'(model_regs[ra2]);
        exp_v = ref_alu(op, int'(model_regs[ra1]), b_val);
        #1;
        if (do_check) begin
            check_val({tag, "_model"}, ALUResult, exp_v);
            if (have_want) check_val({tag, "_const"}, ALUResult, want);
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        end else if (we) begin
            model_regs[wa] = exp_v;
        end
    endtask

    // Read register r through pass-B with no write, and compare to a constant.
    task automatic read_reg(input string tag, input logic [3:0] r, input logic [7:0] want);
        cycle(tag, 4'd0, r, 4'd0, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, want);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        RA1 = 4'd0; RA2 = 4'd0; WA = 4'd0; external_data_in = 8'h00;
        RegWrite = 1'b0; ALUSrc = 1'b0; ALUControl = 2'd0; reset = 1'b1;

        // Reset clears everything (registers unknown beforehand, so no check).
        cycle("rst", 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle("rst_add", 4'd9, 4'd3, 4'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h00);

        // Reset overrides a simultaneous write.
        cycle("ld_pre", 4'd0, 4'd0, 4'd2, 8'h55, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 8'h55);
        read_reg("pre_rd2", 4'd2, 8'h55);
        cycle("rst_we", 4'd0, 4'd0, 4'd2, 8'h77, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 8'h77);
        read_reg("rst_we_rd2", 4'd2, 8'h00);

        // Load via pass-B.
        cycle("ld1", 4'd0, 4'd0, 4'd2, 8'h01, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 8'h01);
        cycle("ld4", 4'd0, 4'd0, 4'd4, 8'h04, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 8'h04);
        cycle("ld5", 4'd0, 4'd0, 4'd5, 8'h05, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 8'h05);

        // All ops on regs[5]=5, regs[4]=4.
        cycle("op_add", 4'd5, 4'd4, 4'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h09);
        cycle("op_pass", 4'd5, 4'd4, 4'd0, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 8'h04);
        cycle("op_and", 4'd5, 4'd4, 4'd0, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 8'h04);
        cycle("op_sub", 4'd5, 4'd4, 4'd0, 8'h00, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'h01);
        cycle("op_subw", 4'd4, 4'd5, 4'd0, 8'h00, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'hFF);

        // Immediate operand with overflow, written back to r7.
        cycle("imm", 4'd5, 4'd0, 4'd7, 8'hFE, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 8'h03);
        cycle("imm_rd", 4'd7, 4'd7, 4'd0, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 8'h03);

        // Read-during-write: old value seen, increments once per clock.
        cycle("ld3", 4'd0, 4'd0, 4'd3, 8'h10, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 8'h10);
        cycle("rdw0", 4'd3, 4'd0, 4'd3, 8'h01, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 8'h11);
        cycle("rdw1", 4'd3, 4'd0, 4'd3, 8'h01, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 8'h12);
        read_reg("rdw_rd3", 4'd3, 8'h12);

        // Write disable: varying WA/ext must not disturb anything.
        for (int i = 0; i < 6; i++) begin
            cycle("wdis", 4'(i), 4'(i + 3), 4'(i * 5), 8'(i * 37 + 11), 1'b0, 1'b1, 2'(i),
                  1'b0, 1'b1, 1'b0, 8'h00);
        end
        read_reg("wdis_r2", 4'd2, 8'h01);
        read_reg("wdis_r4", 4'd4, 8'h04);
        read_reg("wdis_r5", 4'd5, 8'h05);
        read_reg("wdis_r7", 4'd7, 8'h03);
        read_reg("wdis_r3", 4'd3, 8'h12);

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                  8'($urandom_range(255)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  2'($urandom_range(3)), ($urandom_range(31) == 0) ? 1'b1 : 1'b0,
                  1'b1, 1'b0, 8'h00);
        end

        // Final full readback of the array.
        for (int i = 0; i < 16; i++) begin
            read_reg("final_rd", 4'(i), model_regs[i]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_file_alu.md
Name: reg_file_alu

Overview:
- 16-entry × 8-bit register file with two combinational read ports and one synchronous write port.
- A 2-bit-controlled 8-bit ALU is fed from read port 1 and a mux selecting read port 2 or an external byte.
- The ALU result is both the block output and the write-back data, giving a minimal single-cycle datapath slice for lab-CPU bring-up.

Parameters:
- DATA_W, 8, datapath and register width.
- ADDR_W, 4, register address width (2**ADDR_W = 16 registers).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all registers.
- RA1  input  4  read address, port 1 (ALU operand A).
- RA2  input  4  read address, port 2 (ALU operand B when ALUSrc=0).
- WA  input  4  write address.
- external_data_in  input  8  external operand (ALU operand B when ALUSrc=1).
- RegWrite  input  1  write enable.
- ALUSrc  input  1  operand-B select: 0 = RD2, 1 = external_data_in.
- ALUControl  input  2  ALU operation select.
- ALUResult  output  8  combinational ALU result, also the write-back data.
- Port declaration order is fixed for positional instantiation: RA1, RA2, WA, external_data_in, clk, reset, RegWrite, ALUSrc, ALUControl, ALUResult.

Behaviour:
- Storage: regs[0..15], 8 bits each. Register 0 is an ordinary writable register (not hardwired to zero).
- Reads:
  - RD1 = regs[RA1] and RD2 = regs[RA2], purely combinational with zero latency.
  - X/Z address gives X data; no special handling.
- Operand B: B = ALUSrc ? external_data_in : RD2. A = RD1.
- ALU (combinational, 8-bit, modulo 2^8, no carry/overflow/zero flags):
  - 00: A + B
  - 01: B (pass-through / load)
  - 10: A & B
  - 11: A − B (two's-complement wrap)
- Write: at rising clk, if reset=0 and RegWrite=1, regs[WA] <= ALUResult.
- The written value is visible on read ports from the cycle after the edge.
- Read-during-write (RA1 or RA2 == WA in the same cycle): the read returns the old value; there is no bypass.
- Reset:
  - At rising clk with reset=1, all 16 registers <= 0.
  - Reset has priority over RegWrite.
  - Reset asserted mid-operation discards any write in that cycle.
- ALUResult has no reset value of its own. After reset with defined inputs, it follows the ALU function of zeroed registers (e.g. 00 with ALUSrc=0 gives 0).
- Combinational loop: write-back data is ALUResult, but the loop is broken by the register, so ALUResult never depends on the value being written in the same cycle.
- RegWrite=0 leaves all registers unchanged regardless of the other inputs.

Decomposition:
- Package reg_file_alu_pkg:
  - DATA_W and ADDR_W localparams.
  - typedef enum logic [1:0] alu_op_t {ALU_ADD=2'b00, ALU_PASSB=2'b01, ALU_AND=2'b10, ALU_SUB=2'b11}.
- One natural sub-module, alu8: a purely combinational ALU (a, b, op -> y).
- The register array, read muxes and operand-B mux stay in the top level.

Test Plan:
- Reset clears: reset=1 for one edge, then RA1=RA2=any, ALUSrc=0, ALUControl=00 -> ALUResult=0x00. Also: RegWrite=1 while reset=1 -> no register written.
- Load via pass-B: RegWrite=1, ALUSrc=1, ALUControl=01, then on successive edges:
  - ext=1, WA=2
  - ext=4, WA=4
  - ext=5, WA=5
  - Then RegWrite=0, RA1=5, RA2=4, ALUSrc=0, ALUControl=11 -> ALUResult=0x01.
- All ops after loading regs[5]=5, regs[4]=4 (RA1=5, RA2=4, ALUSrc=0):
  - 00 -> 0x09
  - 01 -> 0x04
  - 10 -> 0x04
  - 11 -> 0x01
  - Swap RA1/RA2 with 11 -> 0xFF (wrap).
- Immediate operand: RA1=5, ALUSrc=1, ext=0xFE, ALUControl=00 -> 0x03 (overflow wraps). Writing to WA=7, then reading RA1=7 with ALUControl=01, ALUSrc=0, RA2=7 -> 0x03.
- Read-during-write: regs[3]=0x10; RA1=3, WA=3, ALUSrc=1, ext=1, ALUControl=00, RegWrite=1:
  - Before the edge, ALUResult=0x11.
  - After the edge, regs[3]=0x11 and ALUResult=0x12, i.e. the loop increments once per clock.
- Write disable: RegWrite=0 with varying WA/ext over several edges -> previously written registers are unchanged on readback.
